// File: rtl/gray_pkg.sv
// rtl/gray_pkg.sv - shared constants for the Gray conversion arbiter
package gray_pkg;

   localparam int DATA_W = 4;

   localparam logic [0:0] ST_EMPTY = 1'b0;
   localparam logic [0:0] ST_FULL  = 1'b1;

endpackage

// File: rtl/gray_conv_arbiter_if.sv
// rtl/gray_conv_arbiter_if.sv - requester, result and counter signals of the Gray conversion arbiter
interface gray_conv_arbiter_if #(
   parameter int CNT_W = 8
);
   import gray_pkg::*;

   logic              req0_valid;
   logic [DATA_W-1:0] req0_bin;
   logic              req0_ready;
   logic              req1_valid;
   logic [DATA_W-1:0] req1_bin;
   logic              req1_ready;
   logic              out_valid;
   logic [DATA_W-1:0] out_gray;
   logic [DATA_W-1:0] out_bin;
   logic              out_id;
   logic              out_ready;
   logic [CNT_W-1:0]  conv_count;

   modport slave (
      input  req0_valid, req0_bin, req1_valid, req1_bin, out_ready,
      output req0_ready, req1_ready, out_valid, out_gray, out_bin, out_id, conv_count
   );

   modport master (
      output req0_valid, req0_bin, req1_valid, req1_bin, out_ready,
      input  req0_ready, req1_ready, out_valid, out_gray, out_bin, out_id, conv_count
   );

endinterface

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-input round-robin grant selection
module rr_arb2 (
   input  logic [1:0] req,
   input  logic       last_grant,
   output logic       grant
);

   // With contention the requester that did not win last time goes next;
   // with no request the value is irrelevant because the top gates readies.
   always_comb begin
      grant = 1'b0;
      case (req)
         2'b01:   grant = 1'b0;
         2'b10:   grant = 1'b1;
         2'b11:   grant = ~last_grant;
         default: grant = 1'b0;
      endcase
   end

endmodule

// File: rtl/gray_conv_arbiter.sv
// rtl/gray_conv_arbiter.sv - two-requester binary-to-Gray converter with a one-entry result register
module gray_conv_arbiter
   import gray_pkg::*;
#(
   parameter int CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   gray_conv_arbiter_if.slave   bus
);

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [0:0]        state_q, state_d;
   logic              last_grant_q;
   logic [DATA_W-1:0] gray_q, bin_q;
   logic              id_q;
   logic [CNT_W-1:0]  cnt_q;

   logic [1:0]        req;
   logic              grant;
   logic              accept;
   logic              xfer;
   logic [DATA_W-1:0] sel_bin;
   logic [DATA_W-1:0] gray_d;

   assign req = {bus.req1_valid, bus.req0_valid};

   rr_arb2 u_arb (
      .req        (req),
      .last_grant (last_grant_q),
      .grant      (grant)
   );

   assign accept  = (state_q == ST_EMPTY) || bus.out_ready;
   assign xfer    = rst_n && accept && (|req);
   assign sel_bin = grant ? bus.req1_bin : bus.req0_bin;
   assign gray_d  = sel_bin ^ (sel_bin >> 1);

   assign bus.req0_ready = xfer && !grant;
   assign bus.req1_ready = xfer && grant;

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_EMPTY: if (xfer) state_d = ST_FULL;
         ST_FULL:  if (bus.out_ready && !xfer) state_d = ST_EMPTY;
         default:  state_d = ST_EMPTY;
      endcase
   end

   // last_grant resets to 1 so requester 0 wins the first contention.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_EMPTY;
         last_grant_q <= 1'b1;
         gray_q       <= '0;
         bin_q        <= '0;
         id_q         <= 1'b0;
         cnt_q        <= '0;
      end else begin
         state_q <= state_d;
         if (xfer) begin
            last_grant_q <= grant;
            gray_q       <= gray_d;
            bin_q        <= sel_bin;
            id_q         <= grant;
            cnt_q        <= cnt_q + CNT_ONE;
         end
      end
   end

   assign bus.out_valid  = (state_q == ST_FULL);
   assign bus.out_gray   = gray_q;
   assign bus.out_bin    = bin_q;
   assign bus.out_id     = id_q;
   assign bus.conv_count = cnt_q;

endmodule
